// File: rtl/noc_credit_rx_buffer.sv
// Receive-side flit buffer for one router output port: credit-based input, valid/ready output.
// Returns one credit per drained flit and flags overflow and in-packet dest changes.
module noc_credit_rx_buffer #(
   parameter int FLIT_WIDTH   = 32,
   parameter int DEST_WIDTH   = 6,
   parameter int BUFFER_DEPTH = 2,
   parameter int PTR_WIDTH    = $clog2(BUFFER_DEPTH) + 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [FLIT_WIDTH-1:0] data_in,
   input  logic [DEST_WIDTH-1:0] dest_in,
   input  logic                  is_tail_in,
   input  logic                  send_in,
   output logic                  credit_out,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [FLIT_WIDTH-1:0] out_data,
   output logic [DEST_WIDTH-1:0] out_dest,
   output logic                  out_last,
   output logic [PTR_WIDTH-1:0]  occupancy,
   output logic                  err_overflow,
   output logic                  err_dest_change
);

   localparam int IDX_WIDTH = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
   localparam logic [PTR_WIDTH-1:0] DEPTH_COUNT = PTR_WIDTH'(BUFFER_DEPTH);
   localparam logic [IDX_WIDTH-1:0] LAST_IDX    = IDX_WIDTH'(BUFFER_DEPTH - 1);

   logic [FLIT_WIDTH-1:0] data_mem [BUFFER_DEPTH];
   logic [DEST_WIDTH-1:0] dest_mem [BUFFER_DEPTH];
   logic                  last_mem [BUFFER_DEPTH];

   logic [IDX_WIDTH-1:0]  wr_ptr;
   logic [IDX_WIDTH-1:0]  rd_ptr;
   logic                  pkt_open;
   logic [DEST_WIDTH-1:0] pkt_dest;

   logic full;
   logic pop;
   logic push_ok;
   logic push_drop;
   logic dest_mismatch;

   // Pointers wrap explicitly so non-power-of-2 depths work.
   function automatic logic [IDX_WIDTH-1:0] next_idx(input logic [IDX_WIDTH-1:0] idx);
      return (idx == LAST_IDX) ? '0 : idx + IDX_WIDTH'(1);
   endfunction

   assign out_valid     = (occupancy != '0);
   assign full          = (occupancy == DEPTH_COUNT);
   assign pop           = out_valid & out_ready;
   // A pop in the same cycle frees the slot the full-buffer push lands in.
   assign push_ok       = send_in & (~full | pop);
   assign push_drop     = send_in & full & ~pop;
   assign dest_mismatch = push_ok & pkt_open & (dest_in != pkt_dest);

   assign out_data = data_mem[rd_ptr];
   assign out_dest = dest_mem[rd_ptr];
   assign out_last = last_mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst_n && push_ok) begin
         data_mem[wr_ptr] <= data_in;
         dest_mem[wr_ptr] <= dest_in;
         last_mem[wr_ptr] <= is_tail_in;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         occupancy  <= '0;
         credit_out <= 1'b0;
      end else begin
         credit_out <= pop;
         if (push_ok) begin
            wr_ptr <= next_idx(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= next_idx(rd_ptr);
         end
         if (push_ok && !pop) begin
            occupancy <= occupancy + PTR_WIDTH'(1);
         end else if (pop && !push_ok) begin
            occupancy <= occupancy - PTR_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pkt_open        <= 1'b0;
         pkt_dest        <= '0;
         err_overflow    <= 1'b0;
         err_dest_change <= 1'b0;
      end else begin
         if (push_ok) begin
            pkt_open <= ~is_tail_in;
            if (!pkt_open) begin
               pkt_dest <= dest_in;
            end
         end
         if (push_drop) begin
            err_overflow <= 1'b1;
         end
         if (dest_mismatch) begin
            err_dest_change <= 1'b1;
         end
      end
   end

endmodule
